mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 24 ++
 rtl/mdu_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Bus between the E-stage issue logic and the multiply/divide unit.
// The master side drives the instruction and its operands; the slave side
// (the MDU) returns the start strobe, busy flag, HI/LO and mfhi/mflo data.
interface mdu_ctrl_if;
  logic        valid;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output valid, md_op, rs_data, rt_data,
    input  start, busy, hi, lo, md_out
  );

  modport slave (
    input  valid, md_op, rs_data, rt_data,
    output start, busy, hi, lo, md_out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with fixed-latency busy window.
// The result is computed into pending registers when the operation is
// accepted and only copied into HI/LO on the last busy cycle, so the
// architectural registers keep their old values for the whole window.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r, load_cnt_s;
  logic [31:0]        hi_r, lo_r, pend_hi_r, pend_lo_r;
  logic               pend_we_r;
  logic               is_mul_s, is_div_s, is_sgn_s, is_mthi_s, is_mtlo_s;
  logic               start_s, busy_s, done_s, mt_hi_s, mt_lo_s;
  logic [31:0]        calc_hi_s, calc_lo_s, md_out_s;
  logic               calc_we_s;

  // Signed 32x32 -> 64 product.
  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so
  // 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow. A zero
  // divisor is replaced by 1 only to keep the arithmetic defined; that
  // result is never committed.
  function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, q, r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    mag_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    q = (neg_a ^ neg_b) ? (~q + 32'd1) : q;
    r = neg_a ? (~r + 32'd1) : r;
    return {r, q};
  endfunction

  // Decode md_op into operation classes; unknown codes behave as none.
  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    is_sgn_s  = 1'b0;
    is_mthi_s = 1'b0;
    is_mtlo_s = 1'b0;
    case (bus.md_op)
      OP_MULT:  begin is_mul_s = 1'b1; is_sgn_s = 1'b1; end
      OP_MULTU: begin is_mul_s = 1'b1; end
      OP_DIV:   begin is_div_s = 1'b1; is_sgn_s = 1'b1; end
      OP_DIVU:  begin is_div_s = 1'b1; end
      OP_MTHI:  begin is_mthi_s = 1'b1; end
      OP_MTLO:  begin is_mtlo_s = 1'b1; end
      default:  begin is_mul_s = 1'b0; end
    endcase
  end

  // Result and latency for the operation being offered this cycle.
  always_comb begin
    calc_hi_s  = 32'd0;
    calc_lo_s  = 32'd0;
    calc_we_s  = 1'b0;
    load_cnt_s = CNT_W'(0);
    if (is_mul_s) begin
      {calc_hi_s, calc_lo_s} = is_sgn_s ? mul_signed(bus.rs_data, bus.rt_data)
                                        : mul_unsigned(bus.rs_data, bus.rt_data);
      calc_we_s  = 1'b1;
      load_cnt_s = CNT_W'(MULT_CYCLES);
    end else if (is_div_s) begin
      {calc_hi_s, calc_lo_s} = div_calc(bus.rs_data, bus.rt_data, is_sgn_s);
      calc_we_s  = (bus.rt_data != 32'd0);
      load_cnt_s = CNT_W'(DIV_CYCLES);
    end else begin
      calc_we_s  = 1'b0;
    end
  end

  // Output decode: handshake strobes, busy flag and mfhi/mflo read data.
  always_comb begin
    busy_s  = (state_r == ST_RUN);
    start_s = bus.valid & ~reset & ~busy_s & (is_mul_s | is_div_s);
    mt_hi_s = bus.valid & ~reset & ~busy_s & is_mthi_s;
    mt_lo_s = bus.valid & ~reset & ~busy_s & is_mtlo_s;
    done_s  = busy_s & (cnt_r <= CNT_W'(1));
    md_out_s = 32'd0;
    if (bus.valid) begin
      case (bus.md_op)
        OP_MFHI: md_out_s = hi_r;
        OP_MFLO: md_out_s = lo_r;
        default: md_out_s = 32'd0;
      endcase
    end else begin
      md_out_s = 32'd0;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> IDLE on the last cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx_s = ST_RUN;
        else         state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (done_s) state_nx_s = ST_IDLE;
        else        state_nx_s = ST_RUN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Counter, pending result and architectural HI/LO; reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= CNT_W'(0);
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
    end else if (start_s) begin
      cnt_r     <= load_cnt_s;
      pend_hi_r <= calc_hi_s;
      pend_lo_r <= calc_lo_s;
      pend_we_r <= calc_we_s;
    end else if (busy_s) begin
      cnt_r <= done_s ? CNT_W'(0) : (cnt_r - CNT_W'(1));
      if (done_s && pend_we_r) begin
        hi_r <= pend_hi_r;
        lo_r <= pend_lo_r;
      end
    end else if (mt_hi_s) begin
      hi_r <= bus.rs_data;
    end else if (mt_lo_s) begin
      lo_r <= bus.rs_data;
    end
  end

  assign bus.start  = start_s;
  assign bus.busy   = busy_s;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;
  assign bus.md_out = md_out_s;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed operations push their expected HI/LO and busy
// length into a scoreboard; a monitor pops and compares each time busy drops.
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   proto_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] old_hi, old_lo;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an accepted op; returns one time unit into the first busy cycle.
  task automatic start_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo, input int len,
                          input string name);
    exp_t e;
    bus.valid = 1'b1; bus.md_op = op; bus.rs_data = rs; bus.rt_data = rt;
    old_hi = bus.hi; old_lo = bus.lo;
    e.hi = ehi; e.lo = elo; e.len = len; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    check32({name, " start"}, {31'd0, bus.start}, 32'd1);
    step();
    bus.valid = 1'b0; bus.md_op = 4'd0;
    check32({name, " busy_first"}, {31'd0, bus.busy}, 32'd1);
  endtask

  // Wait for busy to drop, checking HI/LO hold their old values meanwhile.
  task automatic wait_done(input string name);
    int guard = 0;
    while (bus.busy && guard < 64) begin
      check32({name, " hi_hold"}, bus.hi, old_hi);
      check32({name, " lo_hold"}, bus.lo, old_lo);
      step();
      guard++;
    end
    check32({name, " busy_timeout"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Scoreboard monitor: measure each busy window and compare on its end.
  int   run_len = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy) begin
      run_len = run_len + 1;
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_underflow: got completion want none");
      end else begin
        e = exp_q.pop_front();
        check32({e.name, " hi"}, bus.hi, e.hi);
        check32({e.name, " lo"}, bus.lo, e.lo);
        check32({e.name, " busy_len"}, run_len, e.len);
      end
      run_len = 0;
    end
    prev_busy = bus.busy;
  end

  // Protocol watcher: any md_op 1-6 offered while busy is an upstream error.
  always @(negedge clk) begin
    if (bus.valid && bus.busy && bus.md_op >= 4'd1 && bus.md_op <= 4'd6) begin
      proto_err++;
      $display("protocol error: md_op %0d offered while busy", bus.md_op);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.valid = 1'b0; bus.md_op = 4'd0; bus.rs_data = 32'd0; bus.rt_data = 32'd0;
    step(); step();

    // A valid mult while reset is high must not start anything.
    bus.valid = 1'b1; bus.md_op = 4'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd3;
    @(negedge clk);
    check32("start_in_reset", {31'd0, bus.start}, 32'd0);
    check32("reset_busy", {31'd0, bus.busy}, 32'd0);
    check32("reset_hi", bus.hi, 32'd0);
    check32("reset_lo", bus.lo, 32'd0);
    step();
    bus.valid = 1'b0; bus.md_op = 4'd0; reset = 1'b0;
    check32("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    // Arithmetic, back-to-back.
    start_op(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult_m2x3");
    wait_done("mult_m2x3");
    start_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, "multu_max");
    wait_done("multu_max");
    start_op(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_m7d2");
    wait_done("div_m7d2");
    start_op(4'd4, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10, "divu_m7d2");
    wait_done("divu_m7d2");
    start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, "div_ovf");
    wait_done("div_ovf");

    // mthi, then divide by zero leaves HI/LO untouched.
    bus.valid = 1'b1; bus.md_op = 4'd5; bus.rs_data = 32'h1234_5678;
    step();
    bus.valid = 1'b0; bus.md_op = 4'd0;
    check32("mthi_hi", bus.hi, 32'h1234_5678);
    check32("mthi_lo", bus.lo, 32'h8000_0000);
    start_op(4'd4, 32'd5, 32'd0, 32'h1234_5678, 32'h8000_0000, 10, "divu_by0");
    wait_done("divu_by0");

    // Read paths.
    bus.valid = 1'b1; bus.md_op = 4'd7;
    @(negedge clk);
    check32("mfhi", bus.md_out, 32'h1234_5678);
    bus.md_op = 4'd8;
    @(negedge clk);
    check32("mflo", bus.md_out, 32'h8000_0000);
    bus.valid = 1'b0; bus.md_op = 4'd7;
    @(negedge clk);
    check32("mfhi_invalid", bus.md_out, 32'd0);
    bus.valid = 1'b1; bus.md_op = 4'd0;
    @(negedge clk);
    check32("md_out_none", bus.md_out, 32'd0);
    bus.valid = 1'b0;
    step();

    // mtlo while busy is ignored and flagged.
    start_op(4'd1, 32'd7, 32'd6, 32'd0, 32'h0000_002A, 5, "mult_7x6");
    bus.valid = 1'b1; bus.md_op = 4'd6; bus.rs_data = 32'hA5A5_A5A5;
    @(negedge clk);
    check32("mtlo_busy_start", {31'd0, bus.start}, 32'd0);
    step();
    bus.valid = 1'b0; bus.md_op = 4'd0;
    check32("mtlo_busy_lo", bus.lo, 32'h8000_0000);
    wait_done("mult_7x6");

    // Same op and a mult with valid low: no effect.
    bus.valid = 1'b0; bus.md_op = 4'd6; bus.rs_data = 32'hA5A5_A5A5;
    @(negedge clk);
    check32("mtlo_invalid_start", {31'd0, bus.start}, 32'd0);
    step();
    check32("mtlo_invalid_lo", bus.lo, 32'h0000_002A);
    bus.md_op = 4'd1; bus.rs_data = 32'd9; bus.rt_data = 32'd9;
    @(negedge clk);
    check32("mult_invalid_start", {31'd0, bus.start}, 32'd0);
    step();
    bus.md_op = 4'd0;
    check32("mult_invalid_busy", {31'd0, bus.busy}, 32'd0);

    // Reset in the third busy cycle discards the mult.
    start_op(4'd1, 32'd5, 32'd5, 32'd0, 32'd0, 3, "mult_reset_abort");
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check32("abort_busy", {31'd0, bus.busy}, 32'd0);
    check32("abort_hi", bus.hi, 32'd0);
    check32("abort_lo", bus.lo, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check32("abort_no_commit_busy", {31'd0, bus.busy}, 32'd0);
      check32("abort_no_commit_lo", bus.lo, 32'd0);
    end

    // Back-to-back mults after recovery.
    start_op(4'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5, "mult_2p32");
    wait_done("mult_2p32");
    start_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5, "mult_m1xm1");
    wait_done("mult_m1xm1");

    step(); step(); step();
    check32("sb_empty", exp_q.size(), 32'd0);
    check32("protocol_errors", proto_err, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
